// File: rtl/mmio_divider_gen2_pkg.sv
// ----------------------------------------------------------------------------
// mmio_div_pkg : shared FSM states, register map and STATUS bits. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mmio_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GO    = 2'd1,
    CALC  = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_N      = 3'd0;
  localparam logic [2:0] ADDR_D      = 3'd1;
  localparam logic [2:0] ADDR_CIN    = 3'd2;
  localparam logic [2:0] ADDR_Q      = 3'd3;
  localparam logic [2:0] ADDR_R      = 3'd4;
  localparam logic [2:0] ADDR_COUT   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_CTRL   = 3'd7;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DZ   = 1;

endpackage

`default_nettype wire

// File: rtl/div_core.sv
// ----------------------------------------------------------------------------
// div_core : unsigned restoring divider, one quotient bit per clock. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q, den_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] w_rem_in, w_quo_in, w_den_in;
  logic [WIDTH:0]   w_shifted, w_diff;
  logic [WIDTH-1:0] rem_d, quo_d;

  // The start cycle already performs the first step straight from the
  // operand inputs, so WIDTH steps finish in the start cycle plus WIDTH-1.
  always_comb begin
    w_rem_in  = start ? '0 : rem_q;
    w_quo_in  = start ? n  : quo_q;
    w_den_in  = start ? d  : den_q;
    w_shifted = {w_rem_in, w_quo_in[WIDTH-1]};
    w_diff    = w_shifted - {1'b0, w_den_in};
    if (!w_diff[WIDTH]) begin
      rem_d = w_diff[WIDTH-1:0];
      quo_d = {w_quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = w_shifted[WIDTH-1:0];
      quo_d = {w_quo_in[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        den_q  <= d;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 2)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign q    = quo_q;
  assign r    = rem_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: rtl/mmio_divider_gen2.sv
// ----------------------------------------------------------------------------
// mmio_divider_gen2 : MMIO signed/unsigned divider with Cin/Cout handshake. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mmio_divider_gen2
  import mmio_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata
);

  logic [WIDTH-1:0] n_q, d_q, q_q, r_q;
  logic             cin_q, signed_q, dz_q, cout_q, busy_q, qneg_q, rneg_q;
  state_t           state_q;

  logic             w_n_neg, w_d_neg, w_d_zero, w_core_start;
  logic [WIDTH-1:0] w_n_mag, w_d_mag, w_core_q, w_core_r;
  logic             w_core_done, w_core_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q      <= '0;
      d_q      <= '0;
      cin_q    <= 1'b0;
      signed_q <= 1'b0;
    end else if (write) begin
      case (address)
        ADDR_N:    n_q      <= writedata[WIDTH-1:0];
        ADDR_D:    d_q      <= writedata[WIDTH-1:0];
        ADDR_CIN:  cin_q    <= writedata[0];
        ADDR_CTRL: signed_q <= writedata[0];
        default:   ;
      endcase
    end
  end

  assign w_n_neg      = signed_q & n_q[WIDTH-1];
  assign w_d_neg      = signed_q & d_q[WIDTH-1];
  assign w_n_mag      = w_n_neg ? -n_q : n_q;
  assign w_d_mag      = w_d_neg ? -d_q : d_q;
  assign w_d_zero     = (d_q == '0);
  assign w_core_start = (state_q == GO) && !w_d_zero;

  div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .start (w_core_start),
    .n     (w_n_mag),
    .d     (w_d_mag),
    .q     (w_core_q),
    .r     (w_core_r),
    .done  (w_core_done),
    .busy  (w_core_busy)
  );

  // Result signs are latched in GO so CTRL writes mid-flight cannot alter them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cout_q <= 1'b0;
          busy_q <= 1'b0;
          if (cin_q) begin
            state_q <= GO;
            cout_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        GO: begin
          qneg_q <= w_n_neg ^ w_d_neg;
          rneg_q <= w_n_neg;
          if (w_d_zero) begin
            q_q     <= '1;
            r_q     <= n_q;
            dz_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= WAIT0;
          end else begin
            dz_q    <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (w_core_done) begin
            q_q     <= qneg_q ? -w_core_q : w_core_q;
            r_q     <= rneg_q ? -w_core_r : w_core_r;
            busy_q  <= 1'b0;
            state_q <= WAIT0;
          end
        end
        WAIT0: begin
          if (!cin_q) begin
            cout_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    if (read) begin
      case (address)
        ADDR_Q:      readdata = 32'(q_q);
        ADDR_R:      readdata = 32'(r_q);
        ADDR_COUT:   readdata[0] = cout_q;
        ADDR_STATUS: begin
          readdata[STAT_BUSY] = busy_q;
          readdata[STAT_DZ]   = dz_q;
        end
        default:     ;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, writedata, w_core_busy};

endmodule

`default_nettype wire

// File: tb/tb_mmio_divider_gen2.sv
// ----------------------------------------------------------------------------
// tb_mmio_divider_gen2 : scoreboard bench for 16-bit and 8-bit divider builds. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mmio_divider_gen2;
  import mmio_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  a16, a8;
  logic        rd16, rd8, wr16, wr8;
  logic [31:0] rdata16, rdata8, wdata16, wdata8;

  always #5 clk = ~clk;

  mmio_divider_gen2 #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .address   (a16),
    .read      (rd16),
    .readdata  (rdata16),
    .write     (wr16),
    .writedata (wdata16)
  );

  mmio_divider_gen2 #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .address   (a8),
    .read      (rd8),
    .readdata  (rdata8),
    .write     (wr8),
    .writedata (wdata8)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus_wr(input bit w8, input logic [2:0] a, input logic [31:0] dat);
    @(negedge clk);
    if (w8) begin a8 = a; wdata8 = dat; wr8 = 1'b1; end
    else    begin a16 = a; wdata16 = dat; wr16 = 1'b1; end
    @(negedge clk);
    wr8  = 1'b0;
    wr16 = 1'b0;
  endtask

  task automatic bus_rd(input bit w8, input logic [2:0] a, output logic [31:0] dat);
    if (w8) begin a8 = a; rd8 = 1'b1; end
    else    begin a16 = a; rd16 = 1'b1; end
    #1;
    dat  = w8 ? rdata8 : rdata16;
    rd8  = 1'b0;
    rd16 = 1'b0;
  endtask

  function automatic exp_t model(input int w, input bit sgn, input logic [31:0] n, input logic [31:0] d);
    exp_t   e;
    longint mask, un, ud, sn, sd, q, r;
    mask = (longint'(1) << w) - 1;
    un   = longint'(n) & mask;
    ud   = longint'(d) & mask;
    e.st = 32'h0;
    if (ud == 0) begin
      q    = mask;
      r    = un;
      e.st = 32'h2;
    end else if (sgn) begin
      sn = ((un >> (w - 1)) & 1) != 0 ? un - (longint'(1) << w) : un;
      sd = ((ud >> (w - 1)) & 1) != 0 ? ud - (longint'(1) << w) : ud;
      q  = sn / sd;
      r  = sn % sd;
    end else begin
      q = un / ud;
      r = un % ud;
    end
    e.q = 32'(q & mask);
    e.r = 32'(r & mask);
    return e;
  endfunction

  task automatic check_results(input bit w8, input string tag);
    exp_t        e;
    logic [31:0] v;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    bus_rd(w8, ADDR_Q, v);      check({tag, "_q"}, v, e.q);
    bus_rd(w8, ADDR_R, v);      check({tag, "_r"}, v, e.r);
    bus_rd(w8, ADDR_STATUS, v); check({tag, "_status"}, v, e.st);
  endtask

  task automatic run_div(input bit w8, input bit sgn, input logic [31:0] n, input logic [31:0] d,
                         input int exp_lat, input string tag);
    logic [31:0] v, st;
    int          k;
    bus_wr(w8, ADDR_CTRL, {31'd0, sgn});
    bus_wr(w8, ADDR_N, n);
    bus_wr(w8, ADDR_D, d);
    sb.push_back(model(w8 ? 8 : 16, sgn, n, d));
    bus_wr(w8, ADDR_CIN, 32'd1);
    bus_rd(w8, ADDR_COUT, v); check({tag, "_cout_idle"}, v, 32'd0);
    k  = 0;
    st = 32'd1;
    while (st[STAT_BUSY] && k < 64) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus_rd(w8, ADDR_COUT, v); check({tag, "_cout_rise"}, v, 32'd1);
      end
      bus_rd(w8, ADDR_STATUS, st);
    end
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    bus_rd(w8, ADDR_COUT, v); check({tag, "_cout_wait0"}, v, 32'd1);
    @(negedge clk);
    check_results(w8, tag);
    bus_wr(w8, ADDR_CIN, 32'd0);
    bus_rd(w8, ADDR_COUT, v); check({tag, "_cout_hold"}, v, 32'd1);
    @(negedge clk);
    bus_rd(w8, ADDR_COUT, v); check({tag, "_cout_fall"}, v, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, st;
    int          k;
    reset = 1'b1;
    a16 = '0; a8 = '0; rd16 = 1'b0; rd8 = 1'b0; wr16 = 1'b0; wr8 = 1'b0;
    wdata16 = '0; wdata8 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    bus_rd(1'b0, ADDR_Q, v);      check("rst_q", v, 32'd0);
    bus_rd(1'b0, ADDR_R, v);      check("rst_r", v, 32'd0);
    bus_rd(1'b0, ADDR_COUT, v);   check("rst_cout", v, 32'd0);
    bus_rd(1'b0, ADDR_STATUS, v); check("rst_status", v, 32'd0);
    bus_wr(1'b0, ADDR_N, 32'h1234);
    bus_rd(1'b0, ADDR_N, v);      check("unmapped_read", v, 32'd0);

    run_div(1'b0, 1'b0, 32'd100, 32'd7, 18, "u100_7");
    a16 = ADDR_Q; rd16 = 1'b0; #1;
    check("read_low_zero", rdata16, 32'd0);

    run_div(1'b0, 1'b1, 32'hFF9C, 32'd7,      18, "s_m100_7");
    run_div(1'b0, 1'b1, 32'hFF9C, 32'hFFF9,   18, "s_m100_m7");
    run_div(1'b0, 1'b0, 32'd1234, 32'd0,      2,  "dz");
    run_div(1'b0, 1'b1, 32'h8000, 32'hFFFF,   18, "s_ovf");

    // Disturbance in CALC: operand writes and an early Cin drop.
    bus_wr(1'b0, ADDR_CTRL, 32'd0);
    bus_wr(1'b0, ADDR_N, 32'd100);
    bus_wr(1'b0, ADDR_D, 32'd7);
    sb.push_back(model(16, 1'b0, 32'd100, 32'd7));
    bus_wr(1'b0, ADDR_CIN, 32'd1);
    repeat (4) @(negedge clk);
    bus_wr(1'b0, ADDR_N, 32'd5);
    bus_wr(1'b0, ADDR_D, 32'd1);
    bus_wr(1'b0, ADDR_CIN, 32'd0);
    k  = 0;
    st = 32'd1;
    while (st[STAT_BUSY] && k < 64) begin
      @(negedge clk);
      k++;
      bus_rd(1'b0, ADDR_STATUS, st);
    end
    check("dist_latency", 32'(k), 32'd8);
    bus_rd(1'b0, ADDR_COUT, v); check("dist_cout_wait0", v, 32'd1);
    @(negedge clk);
    bus_rd(1'b0, ADDR_COUT, v); check("dist_cout_fall", v, 32'd0);
    check_results(1'b0, "dist");

    // Reset in the middle of CALC.
    bus_wr(1'b0, ADDR_N, 32'd100);
    bus_wr(1'b0, ADDR_D, 32'd7);
    bus_wr(1'b0, ADDR_CIN, 32'd1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_rd(1'b0, ADDR_COUT, v);   check("abort_cout", v, 32'd0);
    bus_rd(1'b0, ADDR_Q, v);      check("abort_q", v, 32'd0);
    bus_rd(1'b0, ADDR_R, v);      check("abort_r", v, 32'd0);
    bus_rd(1'b0, ADDR_STATUS, v); check("abort_status", v, 32'd0);
    repeat (3) @(negedge clk);
    bus_rd(1'b0, ADDR_COUT, v);   check("abort_idle", v, 32'd0);

    run_div(1'b1, 1'b0, 32'd255, 32'd16, 10, "w8_255_16");
    run_div(1'b1, 1'b1, 32'h81,  32'h03, 10, "w8_s");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmio_divider_gen2.md
Name: mmio_divider_gen2

Overview:
- Memory-mapped iterative divider coprocessor for the MSP bus, next generation of the team's fixed 16-bit divider peripheral.
- Width-parametrised: quotient and remainder are both WIDTH bits.
- Adds a signed mode, divide-by-zero detection, and a status register.
- Keeps the same software Cin/Cout four-phase SYNC1/SYNC0 handshake, so existing drivers only need the new register map.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word register select.
- read  in  1  read strobe.
- readdata  out  32  read data; combinational from registers; 0 when read=0 or address is unmapped for reads.
- write  in  1  write strobe.
- writedata  in  32  write data.

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous, active-high.
- Register map:
  - 0 N (W, WIDTH bits)
  - 1 D (W, WIDTH bits)
  - 2 Cin (W, bit0)
  - 3 Q (R)
  - 4 R (R)
  - 5 Cout (R, bit0)
  - 6 STATUS (R): bit0 busy, bit1 dz
  - 7 CTRL (W): bit0 signed
- Readdata is always zero-extended from WIDTH bits, never sign-extended. Writes to read-only addresses are ignored.
- Reset clears N, D, Cin, CTRL, Q, R, dz and the counter; state goes to IDLE; Cout=0, busy=0.
- FSM states: IDLE, GO, CALC, WAIT0.
  - IDLE: Cout=0. Go to GO when Cin=1.
  - GO: Cout=1, busy=1.
    - Latch operands into the core: magnitudes if signed, raw otherwise.
    - Record the result signs: Q negative = N sign xor D sign; R sign = N sign.
    - If D==0: set Q=all-ones, R=N (raw), dz=1, go to WAIT0.
    - Otherwise: dz=0, pulse core start, go to CALC.
  - CALC: Cout=1, busy=1. Core runs one restoring step per cycle for exactly WIDTH cycles. On core done, write Q and R (negated per the recorded signs if signed) and go to WAIT0.
  - WAIT0: Cout=1, busy=0. Go to IDLE when Cin=0.
- Latency: Cin seen high in IDLE at cycle t gives GO at t+1 and WAIT0 at t+2+WIDTH, with Q/R valid from t+2+WIDTH. For divide-by-zero, WAIT0 and valid results are at t+2.
- Cout stays 1 from GO until WAIT0 observes Cin=0. Software reading Cout==0 after SYNC0 is therefore guaranteed fresh results.
- Signed mode truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case: most-negative / -1 gives Q=most-negative, R=0 (natural result, no flag).
- Writes to N, D or CTRL during GO/CALC/WAIT0 update the registers but do not affect the in-flight operation; operands are captured in GO.
- Q, R and dz hold their values until the next completion or reset.
- Cin toggling during CALC is ignored. Cin=0 arriving before done is honoured only once in WAIT0.
- Reset mid-operation aborts immediately; all state returns to reset values.
- Simultaneous write to Cin and Cin sampling: the FSM sees the registered Cin, i.e. one cycle after the write.

Decomposition:
- Package mmio_div_pkg holds:
  - FSM state localparams (IDLE=0, GO=1, CALC=2, WAIT0=3);
  - register address constants ADDR_N..ADDR_CTRL;
  - STATUS bit indices.
- Sub-module div_core holds the unsigned iterative restoring divider.
  - Parameter: WIDTH.
  - Inputs: clk, reset, start, n, d.
  - Outputs: q, r, done (single-cycle pulse), busy.

Test Plan:
- WIDTH=16, unsigned, N=100, D=7, full SYNC1/SYNC0 → Q=14, R=2, dz=0. Cout rises the cycle after Cin is sampled; WAIT0 is reached exactly 18 cycles after Cin is sampled.
- Signed: CTRL=1, N=0xFF9C (-100), D=7 → Q=0xFFF2 (-14), R=0xFFFE (-2). Repeat with D=0xFFF9 (-7) → Q=0x000E, R=0xFFFE.
- Divide by zero: N=1234, D=0 → Q=0xFFFF, R=0x04D2, STATUS=0x2. WAIT0 is reached 2 cycles after Cin is sampled; the next valid divide clears dz.
- Signed overflow: N=0x8000, D=0xFFFF, signed → Q=0x8000, R=0.
- Mid-operation disturbance, part 1: during CALC write N=5, D=1 and drop Cin → the original result (100/7) is delivered, Cout stays 1 until WAIT0, then falls the cycle after.
- Mid-operation disturbance, part 2: assert reset mid-CALC → Cout=0, Q=R=0, STATUS=0. Then run a full divide with WIDTH=8 (255/16 → Q=15, R=15) to check the parametrisation.
